// File: rtl/bus_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bus_sequencer_pkg : opcodes, state encoding and register-index helpers  |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
package bus_sequencer_pkg;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T1   = 2'd1,
      T2   = 2'd2,
      T3   = 2'd3
   } seq_state_t;

   // G and A sit directly above the general registers in the enable vectors.
   function automatic int unsigned g_index(input int unsigned num_gpr);
      return num_gpr;
   endfunction

   function automatic int unsigned a_index(input int unsigned num_gpr);
      return num_gpr + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sequencer_seq_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | seq_decoder : combinational step decoder (state + latched fields ->     |
// | datapath enables and selects)                                           |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module seq_decoder
   import bus_sequencer_pkg::*;
#(
   parameter int NUM_GPR = 16,
   parameter int IDX_W   = 4
) (
   input  seq_state_t         state,
   input  logic [2:0]         func,
   input  logic [IDX_W-1:0]   rx,
   input  logic [IDX_W-1:0]   ry,
   output logic [NUM_GPR+1:0] reg_in,
   output logic [NUM_GPR:0]   reg_out,
   output logic               data_out,
   output logic               addsub,
   output logic               addorxor,
   output logic               done,
   output logic               illegal
);

   localparam int RI_W  = NUM_GPR + 2;
   localparam int RO_W  = NUM_GPR + 1;
   localparam int G_IDX = int'(g_index(NUM_GPR));
   localparam int A_IDX = int'(a_index(NUM_GPR));

   localparam logic [RI_W-1:0] G_IN  = RI_W'(1) << G_IDX;
   localparam logic [RI_W-1:0] A_IN  = RI_W'(1) << A_IDX;
   localparam logic [RO_W-1:0] G_OUT = RO_W'(1) << G_IDX;

   logic            w_idx_bad;
   logic            w_legal;
   logic [RI_W-1:0] w_rx_in;
   logic [RO_W-1:0] w_rx_out;
   logic [RO_W-1:0] w_ry_out;

   // Out-of-range indices can only exist when the index field is wider than needed.
   if (NUM_GPR < (1 << IDX_W)) begin : g_idx_check
      assign w_idx_bad = (32'(rx) >= 32'(NUM_GPR)) || (32'(ry) >= 32'(NUM_GPR));
   end else begin : g_idx_full
      assign w_idx_bad = 1'b0;
   end

   assign w_legal  = (func <= OP_XOR) && !w_idx_bad;
   assign w_rx_in  = RI_W'(1) << rx;
   assign w_rx_out = RO_W'(1) << rx;
   assign w_ry_out = RO_W'(1) << ry;

   always_comb begin
      reg_in   = '0;
      reg_out  = '0;
      data_out = 1'b0;
      addsub   = 1'b0;
      addorxor = 1'b0;
      done     = 1'b0;
      illegal  = 1'b0;
      case (state)
         T1: begin
            if (!w_legal) begin
               done    = 1'b1;
               illegal = 1'b1;
            end else begin
               case (func)
                  OP_MV: begin
                     reg_out = w_ry_out;
                     reg_in  = w_rx_in;
                     done    = 1'b1;
                  end
                  OP_MVI: begin
                     data_out = 1'b1;
                     reg_in   = w_rx_in;
                     done     = 1'b1;
                  end
                  default: begin
                     reg_out = w_rx_out;
                     reg_in  = A_IN;
                  end
               endcase
            end
         end
         T2: begin
            reg_out  = w_ry_out;
            reg_in   = G_IN;
            addsub   = (func == OP_SUB);
            addorxor = (func == OP_XOR);
         end
         T3: begin
            reg_out = G_OUT;
            reg_in  = w_rx_in;
            done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bus_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | bus_sequencer : control FSM for the shared-bus register datapath.       |
// | Optional retired-instruction counter enabled by SEQ_PERF_CNT_EN.        |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module bus_sequencer
   import bus_sequencer_pkg::*;
#(
   parameter int NUM_GPR = 16,
   parameter int IDX_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [2:0]         func,
   input  logic [IDX_W-1:0]   rx,
   input  logic [IDX_W-1:0]   ry,
   output logic [NUM_GPR+1:0] reg_in,
   output logic [NUM_GPR:0]   reg_out,
   output logic               data_out,
   output logic               addsub,
   output logic               addorxor,
   output logic               done,
   output logic               illegal
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0]        retired
`endif
);

   seq_state_t       r_state;
   logic [2:0]       r_func;
   logic [IDX_W-1:0] r_rx;
   logic [IDX_W-1:0] r_ry;
   logic             r_ready;

   assign instr_ready = r_ready;

   // Fields are captured only on acceptance, so later input changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_func  <= '0;
         r_rx    <= '0;
         r_ry    <= '0;
         r_ready <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (instr_valid && r_ready) begin
                  r_func  <= func;
                  r_rx    <= rx;
                  r_ry    <= ry;
                  r_state <= T1;
                  r_ready <= 1'b0;
               end
            end
            T1: begin
               // Single-step instructions (and illegal ones) retire in T1.
               if (done) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= T2;
               end
            end
            T2: r_state <= T3;
            T3: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   seq_decoder #(
      .NUM_GPR (NUM_GPR),
      .IDX_W   (IDX_W)
   ) u_decoder (
      .state    (r_state),
      .func     (r_func),
      .rx       (r_rx),
      .ry       (r_ry),
      .reg_in   (reg_in),
      .reg_out  (reg_out),
      .data_out (data_out),
      .addsub   (addsub),
      .addorxor (addorxor),
      .done     (done),
      .illegal  (illegal)
   );

`ifdef SEQ_PERF_CNT_EN
   logic [15:0] r_retired;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_retired <= '0;
      end else if (done) begin
         r_retired <= r_retired + 16'd1;
      end
   end

   assign retired = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_bus_sequencer : directed and random-stream bench for bus_sequencer   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_bus_sequencer;

   localparam int NUM_GPR = 16;
   localparam int IDX_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               instr_valid;
   logic               instr_ready;
   logic [2:0]         func;
   logic [IDX_W-1:0]   rx;
   logic [IDX_W-1:0]   ry;
   logic [NUM_GPR+1:0] reg_in;
   logic [NUM_GPR:0]   reg_out;
   logic               data_out;
   logic               addsub;
   logic               addorxor;
   logic               done;
   logic               illegal;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0]        retired;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_sequencer #(
      .NUM_GPR (NUM_GPR),
      .IDX_W   (IDX_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .func        (func),
      .rx          (rx),
      .ry          (ry),
      .reg_in      (reg_in),
      .reg_out     (reg_out),
      .data_out    (data_out),
      .addsub      (addsub),
      .addorxor    (addorxor),
      .done        (done),
      .illegal     (illegal)
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired     (retired)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flags packed as {data_out, addsub, addorxor, done, illegal}.
   function automatic logic [31:0] flags();
      return 32'({data_out, addsub, addorxor, done, illegal});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  f;
      logic [3:0]  x, y;
      int          exp_lat, got_lat, accepted, dones;
      logic [31:0] exp_rin;
      logic        ok;
      accepted = 0;
      dones    = 0;

      reset = 1'b1; instr_valid = 1'b0; func = '0; rx = '0; ry = '0;
      tick(); tick();
      check("rst_ready",   32'(instr_ready), 32'd1);
      check("rst_reg_in",  32'(reg_in),      32'd0);
      check("rst_reg_out", 32'(reg_out),     32'd0);
      check("rst_flags",   flags(),          32'd0);
`ifdef SEQ_PERF_CNT_EN
      check("rst_retired", 32'(retired),     32'd0);
`endif
      reset = 1'b0;
      tick();
      check("idle_ready", 32'(instr_ready), 32'd1);

      // MV r3 <- r5
      instr_valid = 1'b1; func = 3'b000; rx = 4'd3; ry = 4'd5;
      tick();
      instr_valid = 1'b0; rx = 4'hF; ry = 4'hE;
      check("mv_t1_reg_out", 32'(reg_out),     32'h0_0020);
      check("mv_t1_reg_in",  32'(reg_in),      32'h0_0008);
      check("mv_t1_flags",   flags(),          32'b00010);
      check("mv_t1_ready",   32'(instr_ready), 32'd0);
      tick();
      check("mv_next_ready", 32'(instr_ready), 32'd1);
      check("mv_next_done",  32'(done),        32'd0);

      // SUB r2 <- r2 - r7
      instr_valid = 1'b1; func = 3'b011; rx = 4'd2; ry = 4'd7;
      tick();
      instr_valid = 1'b0; func = 3'b100;
      check("sub_t1_reg_out", 32'(reg_out), 32'h0_0004);
      check("sub_t1_reg_in",  32'(reg_in),  32'h2_0000);
      check("sub_t1_flags",   flags(),      32'b00000);
      tick();
      check("sub_t2_reg_out", 32'(reg_out),     32'h0_0080);
      check("sub_t2_reg_in",  32'(reg_in),      32'h1_0000);
      check("sub_t2_flags",   flags(),          32'b01000);
      check("sub_t2_ready",   32'(instr_ready), 32'd0);
      tick();
      check("sub_t3_reg_out", 32'(reg_out), 32'h1_0000);
      check("sub_t3_reg_in",  32'(reg_in),  32'h0_0004);
      check("sub_t3_flags",   flags(),      32'b00010);
      tick();
      check("sub_after_ready", 32'(instr_ready), 32'd1);

      // Back-to-back: MVI r4 then XOR r1 ^= r9 with valid held high
      instr_valid = 1'b1; func = 3'b001; rx = 4'd4; ry = 4'd0;
      tick();
      check("mvi_t1_reg_out", 32'(reg_out),     32'h0);
      check("mvi_t1_reg_in",  32'(reg_in),      32'h0_0010);
      check("mvi_t1_flags",   flags(),          32'b10010);
      check("mvi_t1_ready",   32'(instr_ready), 32'd0);
      func = 3'b100; rx = 4'd1; ry = 4'd9;
      tick();
      check("b2b_idle_ready", 32'(instr_ready), 32'd1);
      check("b2b_idle_flags", flags(),          32'd0);
      tick();
      instr_valid = 1'b0;
      check("xor_t1_reg_out", 32'(reg_out),     32'h0_0002);
      check("xor_t1_reg_in",  32'(reg_in),      32'h2_0000);
      check("xor_t1_ready",   32'(instr_ready), 32'd0);
      tick();
      check("xor_t2_reg_out", 32'(reg_out),     32'h0_0200);
      check("xor_t2_reg_in",  32'(reg_in),      32'h1_0000);
      check("xor_t2_flags",   flags(),          32'b00100);
      check("xor_t2_ready",   32'(instr_ready), 32'd0);
      tick();
      check("xor_t3_reg_out", 32'(reg_out),     32'h1_0000);
      check("xor_t3_reg_in",  32'(reg_in),      32'h0_0002);
      check("xor_t3_flags",   flags(),          32'b00010);
      check("xor_t3_ready",   32'(instr_ready), 32'd0);
      tick();

      // Illegal opcode 110
      instr_valid = 1'b1; func = 3'b110; rx = 4'd2; ry = 4'd3;
      tick();
      instr_valid = 1'b0;
      check("ill_t1_reg_out", 32'(reg_out), 32'h0);
      check("ill_t1_reg_in",  32'(reg_in),  32'h0);
      check("ill_t1_flags",   flags(),      32'b00011);
      tick();
      check("ill_after_ready", 32'(instr_ready), 32'd1);
      check("ill_after_flags", flags(),          32'd0);
`ifdef SEQ_PERF_CNT_EN
      check("ill_retired", 32'(retired), 32'd5);
`endif

      // Reset during T2 of ADD r6 <- r6 + r6
      instr_valid = 1'b1; func = 3'b010; rx = 4'd6; ry = 4'd6;
      tick();
      instr_valid = 1'b0;
      check("add_t1_reg_out", 32'(reg_out), 32'h0_0040);
      check("add_t1_reg_in",  32'(reg_in),  32'h2_0000);
      tick();
      check("add_t2_reg_out", 32'(reg_out), 32'h0_0040);
      check("add_t2_reg_in",  32'(reg_in),  32'h1_0000);
      check("add_t2_flags",   flags(),      32'b00000);
      reset = 1'b1;
      tick();
      check("midrst_ready",   32'(instr_ready), 32'd1);
      check("midrst_reg_in",  32'(reg_in),      32'h0);
      check("midrst_reg_out", 32'(reg_out),     32'h0);
      check("midrst_flags",   flags(),          32'd0);
      reset = 1'b0;
      tick();
      check("postrst_reg_in", 32'(reg_in), 32'h0);
      check("postrst_flags",  flags(),     32'd0);
`ifdef SEQ_PERF_CNT_EN
      check("postrst_retired", 32'(retired), 32'd0);
`endif

      // Random stream with per-step invariants and a small latency model
      for (int n = 0; n < 1000; n++) begin
         f = 3'($urandom_range(0, 7));
         x = 4'($urandom);
         y = 4'($urandom);
         exp_lat = (f == 3'd2 || f == 3'd3 || f == 3'd4) ? 3 : 1;
         exp_rin = (f <= 3'd4) ? (32'd1 << x) : 32'd0;
         instr_valid = 1'b1; func = f; rx = x; ry = y;
         tick();
         accepted++;
         instr_valid = 1'b0; func = 3'($urandom); rx = 4'($urandom); ry = 4'($urandom);
         got_lat = 0;
         for (int c = 1; c <= 6; c++) begin
            ok = $onehot0({reg_out, data_out}) && $onehot0(reg_in) &&
                 (!(addsub || addorxor) || (reg_in == 18'h1_0000));
            check("rnd_invariant",  32'(ok),          32'd1);
            check("rnd_busy_ready", 32'(instr_ready), 32'd0);
            if (c == 2 && exp_lat == 3) begin
               check("rnd_t2_addsub",   32'(addsub),   32'(f == 3'd3));
               check("rnd_t2_addorxor", 32'(addorxor), 32'(f == 3'd4));
            end
            if (done) begin
               got_lat = c;
               dones++;
               check("rnd_done_reg_in",  32'(reg_in),  exp_rin);
               check("rnd_done_illegal", 32'(illegal), 32'(f > 3'd4));
               break;
            end
            tick();
         end
         check("rnd_latency", 32'(got_lat), 32'(exp_lat));
         tick();
         check("rnd_idle_ready", 32'(instr_ready), 32'd1);
         check("rnd_idle_reg_in", 32'(reg_in), 32'h0);
         repeat ($urandom_range(0, 2)) tick();
      end
      check("rnd_done_count", 32'(dones), 32'(accepted));
`ifdef SEQ_PERF_CNT_EN
      check("rnd_retired", 32'(retired), 32'(accepted));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control FSM for the shared-bus register datapath: general registers, A operand register, G result register, add/sub ALU, XOR unit and result mux.
- Accepts one instruction at a time over a valid/ready handshake.
- Generates one-hot register load enables, bus-driver enables and ALU/mux selects, step by step, until the instruction retires.
- Sits between the instruction source (switches/host) and the datapath.

Parameters:
- NUM_GPR, 16, number of general registers. G index = NUM_GPR, A index = NUM_GPR+1.
- IDX_W, 4, register-index width, clog2(NUM_GPR).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_valid  in  1  instruction present on func/rx/ry.
- instr_ready  out  1  sequencer can accept an instruction.
- func  in  3  opcode.
- rx  in  IDX_W  destination / first operand.
- ry  in  IDX_W  source / second operand.
- reg_in  out  NUM_GPR+2  one-hot load enables: [NUM_GPR-1:0] GPRs, [NUM_GPR] G, [NUM_GPR+1] A.
- reg_out  out  NUM_GPR+1  one-hot bus-driver enables: GPRs plus G.
- data_out  out  1  drive external immediate data onto the bus.
- addsub  out  1  0 = add, 1 = subtract.
- addorxor  out  1  result mux select: 0 = ALU, 1 = XOR.
- done  out  1  one-cycle pulse in the final step of an instruction.
- illegal  out  1  one-cycle pulse when an undefined opcode is accepted.

Behaviour:
- Reset: state IDLE. instr_ready=1. All other outputs 0. Latched fields cleared.
- Opcodes:
  - 000 MV: rx <- ry.
  - 001 MVI: rx <- data.
  - 010 ADD: rx <- rx+ry.
  - 011 SUB: rx <- rx-ry.
  - 100 XOR: rx <- rx^ry.
  - 101-111: illegal.
- States: IDLE, T1, T2, T3.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch func/rx/ry and go to T1.
  - Otherwise stay in IDLE.
- T1, all opcodes, as follows:
  - MV: reg_out[ry], reg_in[rx], done; next IDLE.
  - MVI: data_out, reg_in[rx], done; next IDLE.
  - ADD/SUB/XOR: reg_out[rx], reg_in[A]; next T2.
  - illegal: no enables, done and illegal pulse; next IDLE.
- T2: reg_out[ry], reg_in[G]. addsub=1 for SUB only. addorxor=1 for XOR only. Next T3.
- T3: reg_out[G], reg_in[rx], done; next IDLE.
- Outputs are Moore, decoded from state and the latched fields only. Input changes after acceptance have no effect.
- instr_ready=0 in T1-T3. The next instruction is accepted no earlier than the cycle after done.
- Latency, acceptance edge to done cycle: MV/MVI/illegal 1 cycle; ALU ops 3 cycles.
- Invariants:
  - At most one of reg_out bits and data_out is high in any cycle.
  - reg_in is zero or one-hot.
  - addsub and addorxor are 0 outside T2.
- rx==ry is legal. MV rx,rx drives and loads the same register, giving a no-op write. ADD rx,rx doubles rx.
- Reset asserted in any state: next cycle IDLE with all outputs 0. The in-flight instruction is discarded; no done, no partial writes after the reset edge.
- Index out of range (rx or ry >= NUM_GPR, only possible when NUM_GPR < 2^IDX_W): treated as illegal.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds output retired [15:0]. It resets to 0, increments on every done pulse (including illegal) and wraps 0xFFFF -> 0x0000.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - opcode constants: OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_XOR;
  - state encoding: IDLE/T1/T2/T3;
  - index helpers for G and A.
- One sub-module: seq_decoder, purely combinational. It maps (state, func, rx, ry) to reg_in/reg_out/data_out/addsub/addorxor/done/illegal. The top holds the state register, field latches and optional counter.

Test Plan:
- MV: after reset, MV rx=3 ry=5 -> T1 shows reg_out=bit5 and reg_in=bit3 with done=1; instr_ready high the next cycle.
- SUB: rx=2 ry=7 ->
  - T1: reg_out bit2, reg_in A.
  - T2: reg_out bit7, reg_in G, addsub=1, addorxor=0.
  - T3: reg_out G, reg_in bit2, done.
- Back-to-back with instr_valid held high: MVI then XOR -> second accepted the cycle after the first done; XOR T2 has addorxor=1, addsub=0; instr_ready never high in T1-T3.
- Illegal: func=110 -> one cycle with done=1, illegal=1 and all enables 0; retired increments by 1 if SEQ_PERF_CNT_EN.
- Reset mid-operation: reset asserted in T2 of ADD -> next cycle IDLE, all outputs 0, no done.
- Bus exclusivity: random 1000-instruction stream -> assertion that the one-hot/zero invariants hold every cycle and the done count equals the accepted count.
